// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps one read outstanding to
// instruction memory and buffers returned words with their PCs for decode.
module inst_fetch #(
    parameter logic [63:0] BASE  = 64'h0000_0000_8000_0000,
    parameter int unsigned DELTA = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc
);

    localparam int unsigned   PW   = $clog2(DEPTH);
    localparam int unsigned   CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] ST_REQ  = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_DROP = 2'b10;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nx;
    logic [63:0]   r_fetch_pc;
    logic [63:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_fifo_inst [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_space;
    logic          w_req_fire;
    logic          w_push;
    logic          w_pop;
    logic          w_unused;

    // Only word-aligned fetch addresses exist, so the low redirect bits are dropped.
    assign w_unused = ^redirect_pc[1:0];

    assign w_space        = (r_count < FULL);
    assign imem_req_valid = ~rst & ~redirect_valid & (r_state == ST_REQ) & w_space;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    // A response is only kept when it answers a live request and no redirect is flushing it.
    assign w_push     = (r_state == ST_WAIT) & imem_resp_valid & ~redirect_valid;

    assign inst_valid = ~redirect_valid & (r_count != {CW{1'b0}});
    assign w_pop      = inst_valid & inst_ready;
    assign inst       = inst_valid ? r_fifo_inst[r_head] : 32'h0000_0000;
    assign inst_pc    = inst_valid ? r_fifo_pc[r_head]   : 64'h0000_0000_0000_0000;

    // Next fetch state: request, wait for the owed response, or drain a stale one.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_REQ: begin
                if (w_req_fire) begin
                    w_state_nx = ST_WAIT;
                end else begin
                    w_state_nx = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    w_state_nx = ST_REQ;
                end else if (redirect_valid) begin
                    w_state_nx = ST_DROP;
                end else begin
                    w_state_nx = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (imem_resp_valid) begin
                    w_state_nx = ST_REQ;
                end else begin
                    w_state_nx = ST_DROP;
                end
            end
            default: begin
                w_state_nx = ST_REQ;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Fetch PC: redirect wins over the sequential advance on a kept response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= BASE;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[63:2], 2'b00};
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 64'(DELTA);
        end else begin
            r_fetch_pc <= r_fetch_pc;
        end
    end

    // Buffer pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1'b1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1'b1);
                2'b01:   r_count <= r_count - CW'(1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer storage; contents are masked by occupancy, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_tail]   <= r_fetch_pc;
            r_fifo_inst[r_tail] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a bench-side memory, a queue-level model of
// the fetch stream checked every cycle, and literal expectations per scenario.
module tb_inst_fetch;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // memory behaviour knobs set by the scenarios
    int          lat        = 1;
    bit          fixed_en   = 1'b0;
    logic [31:0] fixed_word = 32'h0;

    // memory and model state
    bit          owed     = 1'b0;
    bit          live     = 1'b0;
    int          mem_cnt  = 0;
    logic [63:0] mem_addr = 64'h0;
    logic [63:0] owed_pc  = 64'h0;
    logic [63:0] exp_pc   = BASE;
    logic [63:0] q_pc[$];
    logic [31:0] q_in[$];

    // observed DUT handshakes
    logic [63:0] req_log[$];
    int          req_cyc[$];
    logic [63:0] pop_pc[$];
    logic [31:0] pop_in[$];
    int          first_iv = -1;

    logic        e_req;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [63:0] e_pc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] req_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    function automatic logic [63:0] pop_pc_at(input int i);
        if (i < pop_pc.size()) return pop_pc[i];
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    function automatic logic [31:0] pop_in_at(input int i);
        if (i < pop_in.size()) return pop_in[i];
        return 32'hBAD0_BAD0;
    endfunction

    function automatic int count_word(input logic [31:0] w);
        int n = 0;
        foreach (pop_in[i]) if (pop_in[i] == w) n++;
        return n;
    endfunction

    // Memory answers `lat` cycles after accepting a request.
    always @(posedge clk) begin
        #1;
        imem_resp_valid = owed && (mem_cnt == 1);
        if (imem_resp_valid)
            imem_resp_data = fixed_en ? fixed_word : {mem_addr[31:2], 2'b11};
        else
            imem_resp_data = 32'h0;
    end

    // Compare against the stream model mid-cycle, then advance model and memory.
    always @(negedge clk) begin
        e_req  = !rst && !redirect_valid && !owed && (q_pc.size() < DEPTH);
        e_iv   = !redirect_valid && (q_pc.size() > 0);
        e_inst = e_iv ? q_in[0] : 32'h0;
        e_pc   = e_iv ? q_pc[0] : 64'h0;
        chk("req_valid", {63'h0, imem_req_valid}, {63'h0, e_req});
        chk("req_addr", imem_req_addr, exp_pc);
        chk("inst_valid", {63'h0, inst_valid}, {63'h0, e_iv});
        chk("inst", {32'h0, inst}, {32'h0, e_inst});
        chk("inst_pc", inst_pc, e_pc);

        if (!rst && imem_req_valid && imem_req_ready) begin
            req_log.push_back(imem_req_addr);
            req_cyc.push_back(cyc);
        end
        if (!rst && inst_valid && inst_ready) begin
            pop_pc.push_back(inst_pc);
            pop_in.push_back(inst);
        end
        if (e_iv && first_iv < 0) first_iv = cyc;

        if (rst) begin
            q_pc.delete();
            q_in.delete();
            exp_pc = BASE;
            owed   = 1'b0;
            live   = 1'b0;
        end else begin
            if (e_iv && inst_ready) begin
                void'(q_pc.pop_front());
                void'(q_in.pop_front());
            end
            if (imem_resp_valid && owed) begin
                if (live && !redirect_valid) begin
                    q_pc.push_back(owed_pc);
                    q_in.push_back(imem_resp_data);
                    exp_pc = exp_pc + 64'd4;
                end
                owed = 1'b0;
            end
            if (redirect_valid) begin
                q_pc.delete();
                q_in.delete();
                exp_pc = {redirect_pc[63:2], 2'b00};
                live   = 1'b0;
            end
            if (owed) mem_cnt = mem_cnt - 1;
            if (imem_req_valid && imem_req_ready) begin
                owed     = 1'b1;
                live     = 1'b1;
                owed_pc  = exp_pc;
                mem_addr = imem_req_addr;
                mem_cnt  = lat;
            end
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One reset cycle, then the returned cycle index is the first cycle after rst falls.
    task automatic start_phase(input int l, input bit ir, input bit mr, output int c0);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        fixed_en       = 1'b0;
        lat            = l;
        inst_ready     = ir;
        imem_req_ready = mr;
        tick(1);
        rst = 1'b0;
        req_log.delete();
        req_cyc.delete();
        pop_pc.delete();
        pop_in.delete();
        first_iv = -1;
        c0 = cyc;
    endtask

    initial begin
        int c0;

        // reset values
        tick(2);
        @(negedge clk);
        chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("rst_req_addr", imem_req_addr, 64'h0000_0000_8000_0000);
        chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
        chk("rst_inst", {32'h0, inst}, 64'h0);
        chk("rst_inst_pc", inst_pc, 64'h0);
        tick(1);

        // sequential fetch with a 1-cycle memory returning 32'h00000013
        start_phase(1, 1'b1, 1'b1, c0);
        fixed_en   = 1'b1;
        fixed_word = 32'h0000_0013;
        tick(8);
        chk("p1_req0", req_at(0), 64'h0000_0000_8000_0000);
        chk("p1_req1", req_at(1), 64'h0000_0000_8000_0004);
        chk("p1_req2", req_at(2), 64'h0000_0000_8000_0008);
        chk("p1_req0_cycle", 64'(req_cyc.size() > 0 ? req_cyc[0] - c0 : -1), 64'd0);
        chk("p1_pop_pc0", pop_pc_at(0), 64'h0000_0000_8000_0000);
        chk("p1_pop_pc1", pop_pc_at(1), 64'h0000_0000_8000_0004);
        chk("p1_pop_pc2", pop_pc_at(2), 64'h0000_0000_8000_0008);
        chk("p1_pop_inst0", {32'h0, pop_in_at(0)}, 64'h0000_0013);
        // request cycle, response cycle, then valid: third cycle counting the request
        chk("p1_first_valid_lag", 64'(first_iv - c0), 64'd2);

        // decode stalls: buffer fills, requests stop, then drain and resume
        start_phase(1, 1'b0, 1'b1, c0);
        tick(10);
        chk("p2_req_count", 64'(req_log.size()), 64'd2);
        chk("p2_req_valid_full", {63'h0, imem_req_valid}, 64'h0);
        inst_ready = 1'b1;
        req_log.delete();
        req_cyc.delete();
        tick(6);
        chk("p2_pop_pc0", pop_pc_at(0), 64'h0000_0000_8000_0000);
        chk("p2_pop_pc1", pop_pc_at(1), 64'h0000_0000_8000_0004);
        chk("p2_resume_addr", req_at(0), 64'h0000_0000_8000_0008);
        chk("p2_pop_pc2", pop_pc_at(2), 64'h0000_0000_8000_0008);

        // memory not ready for 4 cycles: request held, exactly one response consumed
        start_phase(1, 1'b1, 1'b0, c0);
        tick(4);
        imem_req_ready = 1'b1;
        tick(1);
        imem_req_ready = 1'b0;
        tick(6);
        chk("p3_req_count", 64'(req_log.size()), 64'd1);
        chk("p3_req_addr", req_at(0), 64'h0000_0000_8000_0000);
        chk("p3_accept_cycle", 64'(req_cyc.size() > 0 ? req_cyc[0] - c0 : -1), 64'd4);
        chk("p3_pop_count", 64'(pop_pc.size()), 64'd1);

        // redirect while waiting: buffered entry flushed, late 0xdeadbeef dropped
        start_phase(1, 1'b0, 1'b1, c0);
        tick(1);
        lat = 3;
        tick(1);
        fixed_en   = 1'b1;
        fixed_word = 32'hDEAD_BEEF;
        tick(1);
        chk("p4_pre_inst_valid", {63'h0, inst_valid}, 64'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_1003;
        tick(1);
        redirect_valid = 1'b0;
        chk("p4_flushed", {63'h0, inst_valid}, 64'h0);
        tick(2);
        fixed_en   = 1'b0;
        lat        = 1;
        inst_ready = 1'b1;
        tick(8);
        chk("p4_redirect_addr", req_at(2), 64'h0000_0000_8000_1000);
        chk("p4_pop_pc0", pop_pc_at(0), 64'h0000_0000_8000_1000);
        chk("p4_no_deadbeef", 64'(count_word(32'hDEAD_BEEF)), 64'd0);

        // redirect in the same cycle as the response
        start_phase(2, 1'b1, 1'b1, c0);
        fixed_en   = 1'b1;
        fixed_word = 32'hDEAD_BEEF;
        tick(2);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_2000;
        tick(1);
        redirect_valid = 1'b0;
        fixed_en       = 1'b0;
        tick(8);
        chk("p5_redirect_addr", req_at(1), 64'h0000_0000_8000_2000);
        chk("p5_redirect_cycle", 64'(req_cyc.size() > 1 ? req_cyc[1] - c0 : -1), 64'd3);
        chk("p5_pop_pc0", pop_pc_at(0), 64'h0000_0000_8000_2000);
        chk("p5_no_deadbeef", 64'(count_word(32'hDEAD_BEEF)), 64'd0);

        // PC wraps from the top of the address space
        start_phase(1, 1'b1, 1'b1, c0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
        tick(1);
        redirect_valid = 1'b0;
        tick(8);
        chk("p6_req0", req_at(0), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("p6_req1_wrap", req_at(1), 64'h0000_0000_0000_0000);
        chk("p6_pop_pc0", pop_pc_at(0), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("p6_pop_inst0", {32'h0, pop_in_at(0)}, 64'hFFFF_FFFF);

        // reset while a response is owed restarts at BASE
        start_phase(5, 1'b0, 1'b1, c0);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        lat = 1;
        req_log.delete();
        req_cyc.delete();
        tick(4);
        chk("p7_req_after_rst", req_at(0), 64'h0000_0000_8000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
